// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream big-endian into words and writes imem.
// Define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  len,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [6:0] MAXW = 7'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [6:0]  n_q, n_d;
  logic [6:0]  wcnt_q, wcnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] w_q, w_d;
  logic        acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
  logic        err_q, err_d;
`endif

  // ready is a pure state decode, so valid never feeds back into it
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign err        = err_q;
`else
  assign byte_ready = (state_q == S_RECV);
  assign err        = 1'b0;
`endif

  assign acc      = byte_valid && byte_ready;
  assign we       = (state_q == S_WRITE);
  assign waddr    = {24'b0, idx_q, 2'b00};
  assign wdata    = w_q;
  assign busy     = (state_q != S_IDLE);
  assign cpu_hold = busy;
  assign done     = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    w_d     = w_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d    = (len > MAXW) ? MAXW : len;
          wcnt_d = '0;
          idx_d  = '0;
          bcnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d  = '0;
          err_d  = 1'b0;
`endif
          state_d = (n_d == 7'd0) ? S_END : S_RECV;
        end
      end
      S_RECV: begin
        if (acc) begin
          w_d    = {w_q[23:0], byte_in};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ byte_in;
`endif
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 6'd1;
        wcnt_d  = wcnt_q + 7'd1;
        state_d = (wcnt_d == n_q) ? S_END : S_RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (acc) begin
          err_d   = (byte_in != xor_q);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      w_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      w_q     <= w_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: vector table, random loads and corner sequences
// against a word-level reference model of the loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  len = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int rdy_in_wr = 0;
  int hold_bad = 0;

  always @(negedge clk) begin
    if (we) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
    if (we && byte_ready) rdy_in_wr++;
    if (cpu_hold !== busy) hold_bad++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, " we"}, 32'(we), 32'd0);
    chk({tag, " waddr"}, waddr, 32'd0);
    chk({tag, " wdata"}, wdata, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
  endtask

  // Reference: word k is bytes 4k..4k+3 big-endian at byte address 4k.
  task automatic run_load(input string tag, input int ln, input bit gaps,
                          input logic [7:0] data[$], input bit bad_cs,
                          input int exp_writes, input logic [31:0] exp_last,
                          input int exp_lat, input bit poke);
    logic [7:0]  strm[$];
    logic [7:0]  x;
    logic [31:0] ew;
    int bi;
    int lat;
    int nw;
    bit acc;
    strm = data;
    x = 8'h00;
    foreach (data[i]) x ^= data[i];
    if (CS) strm.push_back(bad_cs ? (x ^ 8'h01) : x);
    nw = (ln > 64) ? 64 : ln;
    bi = 0;
    lat = -1;
    wa_q.delete();
    wd_q.delete();
    rdy_in_wr = 0;
    hold_bad = 0;
    len = 7'(ln);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 3000 && lat < 0; c++) begin
      if (poke && (c == 40 || c == 41)) begin
        start = 1'b1;
        len = 7'd1;
      end else begin
        start = 1'b0;
      end
      byte_valid = (bi < strm.size()) &&
                   (!gaps || ($urandom_range(0, 2) == 0));
      byte_in = byte_valid ? strm[bi] : 8'h00;
      @(negedge clk);
      acc = byte_valid && byte_ready;
      if (done) lat = c + 1;
      @(posedge clk);
      #1;
      if (acc) bi++;
    end
    start = 1'b0;
    byte_valid = 1'b0;
    chk({tag, " done_seen"}, 32'(lat >= 0), 32'd1);
    chk({tag, " n_writes"}, wa_q.size(), 32'(exp_writes));
    for (int k = 0; k < nw && k < wa_q.size(); k++) begin
      ew = {data[4*k], data[4*k+1], data[4*k+2], data[4*k+3]};
      chk({tag, " waddr"}, wa_q[k], 32'((k % 64) * 4));
      chk({tag, " wdata"}, wd_q[k], ew);
    end
    if (exp_writes > 0 && wa_q.size() > 0)
      chk({tag, " last_waddr"}, wa_q[$], exp_last);
    if (exp_lat >= 0)
      chk({tag, " done_latency"}, 32'(lat), 32'(exp_lat + (CS ? 1 : 0)));
    chk({tag, " bytes_taken"}, 32'(bi), 32'(strm.size()));
    chk({tag, " ready_in_write"}, 32'(rdy_in_wr), 32'd0);
    chk({tag, " hold_eq_busy"}, 32'(hold_bad), 32'd0);
    @(negedge clk);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " err"}, 32'(err), 32'(CS && bad_cs));
  endtask

  function automatic void rnd_bytes(input int ln, output logic [7:0] q[$]);
    int nw;
    nw = (ln > 64) ? 64 : ln;
    q.delete();
    for (int i = 0; i < 4 * nw; i++) q.push_back(8'($urandom));
  endfunction

  typedef struct {
    int          ln;
    bit          gaps;
    bit          poke;
    int          exp_writes;
    logic [31:0] exp_last;
    int          exp_lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [7:0] q[$];
    int ln;
    bit g;

    vt[0] = '{1,   1'b0, 1'b0, 1,  32'h00, 6};
    vt[1] = '{3,   1'b0, 1'b0, 3,  32'h08, 16};
    vt[2] = '{2,   1'b1, 1'b0, 2,  32'h04, -1};
    vt[3] = '{0,   1'b0, 1'b0, 0,  32'h00, 1};
    vt[4] = '{100, 1'b0, 1'b1, 64, 32'hFC, 321};
    vt[5] = '{64,  1'b0, 1'b0, 64, 32'hFC, 321};
    vt[6] = '{65,  1'b1, 1'b0, 64, 32'hFC, -1};

    @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    q = {8'h20, 8'h08, 8'h00, 8'h05};
    run_load("tp1", 1, 1'b0, q, 1'b0, 1, 32'h0, 6, 1'b0);
    if (wd_q.size() > 0) chk("tp1 word", wd_q[0], 32'h20080005);

    for (int i = 0; i < 7; i++) begin
      rnd_bytes(vt[i].ln, q);
      run_load($sformatf("vec%0d", i), vt[i].ln, vt[i].gaps, q, 1'b0,
               vt[i].exp_writes, vt[i].exp_last, vt[i].exp_lat,
               vt[i].poke);
    end

    for (int i = 0; i < 6; i++) begin
      ln = $urandom_range(1, 9);
      g = 1'($urandom_range(0, 1));
      rnd_bytes(ln, q);
      run_load($sformatf("rnd%0d", i), ln, g, q, 1'b0, ln,
               32'((ln - 1) * 4), g ? -1 : 5 * ln + 1, 1'b0);
    end

    q = {8'h01, 8'h02, 8'h03, 8'h04};
    run_load("cs_good", 1, 1'b0, q, 1'b0, 1, 32'h0, 6, 1'b0);
    run_load("cs_bad", 1, 1'b0, q, 1'b1, 1, 32'h0, 6, 1'b0);
    run_load("cs_clear", 1, 1'b1, q, 1'b0, 1, 32'h0, -1, 1'b0);

    // reset after two bytes of the first word
    wa_q.delete();
    len = 7'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    @(posedge clk);
    #1;
    byte_in = 8'hBB;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst no_we", wa_q.size(), 32'd0);
    chk_reset_vals("midrst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rnd_bytes(1, q);
    run_load("post_rst", 1, 1'b0, q, 1'b0, 1, 32'h0, 6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
